// File: rtl/reg_file.sv
// Register file for the CPU datapath: one write port, two bypassed combinational read ports, R0 fixed at zero.
// A valid/ready dump FSM streams every register out in address order for debug.
module reg_file #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             WE,
    input  logic [AW-1:0]    WA,
    input  logic [WIDTH-1:0] WD,
    input  logic [AW-1:0]    RA1,
    output logic [WIDTH-1:0] RD1,
    input  logic [AW-1:0]    RA2,
    output logic [WIDTH-1:0] RD2,
    input  logic             DUMP_START,
    input  logic             DUMP_READY,
    output logic             DUMP_VALID,
    output logic [AW-1:0]    DUMP_ADDR,
    output logic [WIDTH-1:0] DUMP_DATA,
    output logic             DUMP_BUSY,
    output logic             DUMP_DONE
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } dump_state_e;

    logic [WIDTH-1:0] regs_q [DEPTH];

    dump_state_e      state_q;
    logic             dump_valid_q;
    logic             dump_busy_q;
    logic             dump_done_q;
    logic [AW-1:0]    dump_addr_q;
    logic [WIDTH-1:0] dump_data_q;

    logic [AW-1:0]    dump_addr_d;
    logic [WIDTH-1:0] dump_data_d;

    // Returns the value the addressed register will hold after the current edge.
    function automatic logic [WIDTH-1:0] bypass_read(
        input logic [AW-1:0]    ra,
        input logic             we,
        input logic [AW-1:0]    wa,
        input logic [WIDTH-1:0] wd,
        input logic [WIDTH-1:0] stored
    );
        logic [WIDTH-1:0] val;
        if (ra == '0) begin
            val = '0;
        end else if (we && (wa == ra)) begin
            val = wd;
        end else begin
            val = stored;
        end
        return val;
    endfunction

    // Read ports and the next dump beat value.
    always_comb begin
        RD1         = bypass_read(RA1, WE, WA, WD, regs_q[RA1]);
        RD2         = bypass_read(RA2, WE, WA, WD, regs_q[RA2]);
        dump_addr_d = dump_addr_q + AW'(1);
        dump_data_d = bypass_read(dump_addr_d, WE, WA, WD, regs_q[dump_addr_d]);
    end

    // Storage update; address 0 is never written so it stays at zero.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (WE && (WA != '0)) begin
            regs_q[WA] <= WD;
        end else begin
            regs_q[0] <= '0;
        end
    end

    // Dump FSM with registered beat outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            dump_valid_q <= 1'b0;
            dump_busy_q  <= 1'b0;
            dump_done_q  <= 1'b0;
            dump_addr_q  <= '0;
            dump_data_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    dump_done_q <= 1'b0;
                    if (DUMP_START) begin
                        state_q      <= ST_SCAN;
                        dump_valid_q <= 1'b1;
                        dump_busy_q  <= 1'b1;
                        dump_addr_q  <= '0;
                        dump_data_q  <= '0;
                    end else begin
                        state_q      <= ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    dump_done_q <= 1'b0;
                    if (dump_valid_q && DUMP_READY) begin
                        if (dump_addr_q == LAST_ADDR) begin
                            state_q      <= ST_IDLE;
                            dump_valid_q <= 1'b0;
                            dump_busy_q  <= 1'b0;
                            dump_done_q  <= 1'b1;
                        end else begin
                            dump_addr_q  <= dump_addr_d;
                            dump_data_q  <= dump_data_d;
                        end
                    end else begin
                        state_q <= ST_SCAN;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    dump_valid_q <= 1'b0;
                    dump_busy_q  <= 1'b0;
                    dump_done_q  <= 1'b0;
                    dump_addr_q  <= '0;
                    dump_data_q  <= '0;
                end
            endcase
        end
    end

    assign DUMP_VALID = dump_valid_q;
    assign DUMP_BUSY  = dump_busy_q;
    assign DUMP_DONE  = dump_done_q;
    assign DUMP_ADDR  = dump_addr_q;
    assign DUMP_DATA  = dump_data_q;

endmodule

// File: doc/reg_file.md
# reg_file

Register file for the CPU datapath: DEPTH words of WIDTH bits, one synchronous write port, two combinational read ports with write-to-read bypass, and R0 hardwired to zero. A serial dump port, controlled by a valid/ready FSM, streams every register out in address order for debug and self-checking benches. It sits between instruction decode (read addresses) and writeback (write port).

## Interface
- WIDTH, 8, data width in bits
- DEPTH, 8, number of registers; power of two, >= 2
- AW, log2(DEPTH) = 3, address width

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  reset; synchronous, active-high
- WE  in  1  write enable
- WA  in  AW  write address
- WD  in  WIDTH  write data
- RA1  in  AW  read address, port 1
- RD1  out  WIDTH  read data, port 1 (combinational)
- RA2  in  AW  read address, port 2
- RD2  out  WIDTH  read data, port 2 (combinational)
- DUMP_START  in  1  request a full dump; honoured only in IDLE
- DUMP_READY  in  1  consumer accepts the current dump beat
- DUMP_VALID  out  1  dump beat present
- DUMP_ADDR  out  AW  address of the current beat
- DUMP_DATA  out  WIDTH  data of the current beat
- DUMP_BUSY  out  1  FSM is in SCAN
- DUMP_DONE  out  1  one-cycle pulse after the last beat is accepted

## Operation
- Storage: regs[0..DEPTH-1]. A write updates regs[WA] <= WD on the edge when WE=1 and WA!=0. Writes to address 0 are discarded, and regs[0] always reads as 0.
- Reads: RDn = 0 if RAn=0; else WD if WE=1 and WA=RAn (bypass); else regs[RAn]. This is the same value the register will hold after the edge.
- Both read ports are independent. Identical addresses on both ports return identical data.
- Dump FSM has two states: IDLE and SCAN.
  - IDLE -> SCAN on an edge with DUMP_START=1. At that edge: DUMP_ADDR<=0, DUMP_DATA<=0, DUMP_VALID<=1, DUMP_BUSY<=1.
  - In SCAN, a beat is accepted on an edge with DUMP_VALID=1 and DUMP_READY=1.
  - Accept with DUMP_ADDR<DEPTH-1: DUMP_ADDR<=DUMP_ADDR+1, and DUMP_DATA<=the bypassed read of DUMP_ADDR+1, using the rule above (a simultaneous write to that address is captured).
  - Accept with DUMP_ADDR=DEPTH-1: move to IDLE, with DUMP_VALID<=0, DUMP_BUSY<=0, DUMP_DONE<=1.
  - Stall (VALID=1, READY=0): DUMP_ADDR and DUMP_DATA hold. A write to the stalled address is not reflected in DUMP_DATA.
  - DUMP_START in SCAN is ignored. DUMP_READY in IDLE is ignored.
- DUMP_DONE is high for exactly one cycle, then returns to 0. DUMP_START in the DONE cycle is honoured, because the FSM is already in IDLE.
- The dump never blocks the write or read ports.

## Timing
- Reset (RST=1 at an edge): all regs <= 0, FSM <= IDLE, DUMP_VALID/BUSY/DONE <= 0, DUMP_ADDR <= 0, DUMP_DATA <= 0. Reset overrides WE and DUMP_START on the same edge.
- Reset mid-dump aborts the dump: DUMP_VALID=0 after that edge and no DONE pulse.
- Write latency: 1 edge to storage, 0 cycles to the read ports (bypass).
- Dump latency: the first beat is valid 1 cycle after DUMP_START is sampled. With READY held at 1, beats arrive on consecutive cycles (DEPTH cycles total), and DONE follows 1 cycle after the last accept.
- RD1/RD2 are purely combinational from RAn/WE/WA/WD/regs. There is no clocked read path.

## Test plan
- Reset, then read all addresses on both ports -> RD1=RD2=0. Write WA=3,WD=0xA5 with RA1=3 in the same cycle -> RD1=0xA5 that cycle (bypass). The cycle after, with WE=0 -> RD1=0xA5.
- Write WA=0,WD=0xFF -> RD1 with RA1=0 reads 0x00, both during the write cycle and after it.
- Fill regs[i]=0x10+i for i=1..7, then pulse DUMP_START with READY=1 -> 8 consecutive beats (addr,data)=(0,0x00),(1,0x11)..(7,0x17). DONE is high one cycle after beat 7, and BUSY falls on that same edge.
- During a dump, toggle READY 1,0,0,1 -> ADDR/DATA hold while READY=0. Writing WA=2,WD=0x99 on the edge that accepts beat 1 -> beat 2 data=0x99.
- Assert RST while DUMP_ADDR=4 in SCAN -> the next cycle has VALID=BUSY=0, no DONE pulse, and every register reads 0. Then start a new dump -> it begins at addr 0.
- DUMP_START held high for the whole dump -> only one dump runs. DUMP_START still high in the DONE cycle -> a second dump starts, with VALID=1 the next cycle.
